// File: rtl/gemma_acc_pkg.sv
// Shared constants and types for the GEMM accelerator datapath.
// The array dimension and operand width must match the PE array and output processor.
package gemma_acc_pkg;

  localparam int ARRAY_N   = 4;
  localparam int OPERAND_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register with a global advance enable.
// Used once per lane to build the diagonal skew in front of the systolic array.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_pipe[k] <= '0;
      end
    end else if (i_en) begin
      r_pipe[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_input_feeder.sv
// Operand-side front end of the systolic array: accepts one N-lane vector per
// handshake, skews lane i by i cycles, counts the tile depth and flushes with zeros.
module systolic_input_feeder
  import gemma_acc_pkg::*;
#(
  parameter int N      = ARRAY_N,
  parameter int DATA_W = OPERAND_W,
  parameter int K_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [K_W-1:0]      k_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                array_en,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  output logic                busy,
  output logic                done
);

  localparam int FLUSH_W = $clog2(N + 1);

  feeder_state_t      r_state, w_state_next;
  logic [K_W-1:0]     r_k_len, w_k_len_next;
  logic [K_W-1:0]     r_count, w_count_next;
  logic [FLUSH_W-1:0] r_flush_cnt, w_flush_next;
  logic               r_done, w_done_next;
  logic               w_xfer;

  assign in_ready = (r_state == ST_STREAM) && array_en;
  assign w_xfer   = in_valid && in_ready;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k_len     <= '0;
      r_count     <= '0;
      r_flush_cnt <= '0;
      r_done      <= 1'b0;
    end else if (array_en) begin
      r_state     <= w_state_next;
      r_k_len     <= w_k_len_next;
      r_count     <= w_count_next;
      r_flush_cnt <= w_flush_next;
      r_done      <= w_done_next;
    end
  end

  // Everything here is only committed on enabled cycles, so a stall freezes the FSM.
  always_comb begin
    w_state_next = r_state;
    w_k_len_next = r_k_len;
    w_count_next = r_count;
    w_flush_next = r_flush_cnt;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_k_len_next = k_len;
          w_count_next = '0;
          if (k_len == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (in_valid) begin
          w_count_next = r_count + K_W'(1);
          if ((r_count + K_W'(1)) == r_k_len) begin
            w_state_next = ST_FLUSH;
            w_flush_next = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == FLUSH_W'(N - 1)) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_flush_next = r_flush_cnt + FLUSH_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Non-transfer cycles (bubbles, flush, idle) push zero data with valid low.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_W:0] w_lane_in;
      logic [DATA_W:0] w_lane_out;

      assign w_lane_in = {w_xfer, in_data[gi*DATA_W +: DATA_W] & {DATA_W{w_xfer}}};

      skew_delay_line #(
        .DEPTH (gi + 1),
        .WIDTH (DATA_W + 1)
      ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .i_en (array_en),
        .i_d  (w_lane_in),
        .o_q  (w_lane_out)
      );

      assign out_data[gi*DATA_W +: DATA_W] = w_lane_out[DATA_W-1:0];
      assign out_valid[gi]                 = w_lane_out[DATA_W];
    end
  endgenerate

endmodule
